// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: controller state encoding, the x0 register
//                index and the stall counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Controller state: normal flow, or waiting on the multi-cycle mul/div unit
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Architectural zero register; writes to it never create a dependency
  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the saturating stall-cycle counter
  localparam int STALL_CNT_W = 16;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundle of pipeline-side signals seen by the hazard
//                controller. The slave modport is the controller; the master
//                modport is the pipeline datapath that feeds it and obeys it.
//  Revision    : 1.0  initial release
//
//  Signals
//    rs1_ID, rs2_ID   [4:0]  source registers of the instruction in ID
//    memread_EX              load in EX
//    rd_EX            [4:0]  destination of the instruction in EX
//    branch_taken_EX         redirect resolved in EX
//    muldiv_req_EX           mul/div instruction in EX
//    muldiv_done             one-cycle completion pulse from mul/div unit
//    stall_IF/ID/EX          hold PC, IF/ID, ID/EX
//    flush_ID/EX/MEM         bubble into IF/ID, ID/EX, EX/MEM
//    muldiv_start            one-cycle start pulse to mul/div unit
//    stall_cycles     [15:0] saturating count of cycles with stall_IF=1
// ============================================================================
interface pipe_ctrl_if;

  logic [4:0]                            rs1_ID;
  logic [4:0]                            rs2_ID;
  logic                                  memread_EX;
  logic [4:0]                            rd_EX;
  logic                                  branch_taken_EX;
  logic                                  muldiv_req_EX;
  logic                                  muldiv_done;
  logic                                  stall_IF;
  logic                                  stall_ID;
  logic                                  stall_EX;
  logic                                  flush_ID;
  logic                                  flush_EX;
  logic                                  flush_MEM;
  logic                                  muldiv_start;
  logic [pipe_ctrl_pkg::STALL_CNT_W-1:0] stall_cycles;

  // Pipeline datapath side
  modport master (
    output rs1_ID, rs2_ID, memread_EX, rd_EX, branch_taken_EX,
           muldiv_req_EX, muldiv_done,
    input  stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM,
           muldiv_start, stall_cycles
  );

  // Hazard controller side
  modport slave (
    input  rs1_ID, rs2_ID, memread_EX, rd_EX, branch_taken_EX,
           muldiv_req_EX, muldiv_done,
    output stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM,
           muldiv_start, stall_cycles
  );

endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use detector. Flags when the load in EX
//                writes a register that the instruction in ID reads. A load
//                targeting x0 never produces a dependency.
//  Revision    : 1.0  initial release
//
//  Ports
//    rs1_id, rs2_id [4:0]  in   source registers of the instruction in ID
//    memread_ex            in   load in EX
//    rd_ex          [4:0]  in   destination of the load in EX
//    load_use              out  load-use dependency present this cycle
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  wire logic [4:0] rs1_id,
  input  wire logic [4:0] rs2_id,
  input  wire logic       memread_ex,
  input  wire logic [4:0] rd_ex,
  output logic            load_use
);

  logic w_rd_live;
  logic w_src_match;

  assign w_rd_live   = (rd_ex != REG_X0);
  assign w_src_match = (rd_ex == rs1_id) || (rd_ex == rs2_id);
  assign load_use    = memread_ex && w_rd_live && w_src_match;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline hazard controller. Produces stall and flush
//                controls for load-use hazards, taken branches and
//                multi-cycle mul/div operations, and counts front-end stall
//                cycles in a saturating counter.
//                Priority: MD_WAIT > mul/div request > branch > load-use.
//                All controls are combinational from state and inputs; only
//                the state and stall_cycles are registered.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk           in   pipeline clock, rising edge
//    rst           in   asynchronous active-high reset
//    bus           slave modport of pipe_ctrl_if (see that file)
//
//  Configuration
//    PIPE_CTRL_MULDIV_EN  defined: mul/div start/wait handling enabled.
//                         undefined: MD_WAIT unreachable, muldiv_start,
//                         stall_EX and flush_MEM held at 0, mul/div inputs
//                         ignored.
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  pipe_ctrl_if.slave   bus
);

  localparam logic [STALL_CNT_W-1:0] c_stall_cnt_max = '1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   w_load_use;

  logic w_stall_if;
  logic w_stall_id;
  logic w_stall_ex;
  logic w_flush_id;
  logic w_flush_ex;
  logic w_flush_mem;
  logic w_muldiv_start;

  hazard_detect u_hazard_detect (
    .rs1_id     (bus.rs1_ID),
    .rs2_id     (bus.rs2_ID),
    .memread_ex (bus.memread_EX),
    .rd_ex      (bus.rd_EX),
    .load_use   (w_load_use)
  );

`ifndef PIPE_CTRL_MULDIV_EN
  // Mul/div inputs have no consumer in this build
  logic w_unused_muldiv;
  assign w_unused_muldiv = bus.muldiv_req_EX ^ bus.muldiv_done;
`endif

  // Control decode. Gated by rst so every control is 0 while reset is held,
  // independent of the clock.
  always_comb begin
    w_next_state   = r_state;
    w_stall_if     = 1'b0;
    w_stall_id     = 1'b0;
    w_stall_ex     = 1'b0;
    w_flush_id     = 1'b0;
    w_flush_ex     = 1'b0;
    w_flush_mem    = 1'b0;
    w_muldiv_start = 1'b0;
    if (!rst) begin
      if (r_state == MD_WAIT) begin
`ifdef PIPE_CTRL_MULDIV_EN
        // Freeze the front of the pipe until the unit reports done; on the
        // done cycle everything advances so the op is not restarted.
        if (bus.muldiv_done) begin
          w_next_state = RUN;
        end else begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_flush_mem = 1'b1;
        end
`else
        w_next_state = RUN;
`endif
      end
`ifdef PIPE_CTRL_MULDIV_EN
      else if (bus.muldiv_req_EX) begin
        w_muldiv_start = 1'b1;
        w_stall_if     = 1'b1;
        w_stall_id     = 1'b1;
        w_stall_ex     = 1'b1;
        w_flush_mem    = 1'b1;
        w_next_state   = MD_WAIT;
      end
`endif
      else if (bus.branch_taken_EX) begin
        // Wrong-path instructions in IF/ID and ID/EX are discarded, which
        // also makes any load-use stall pointless this cycle.
        w_flush_id = 1'b1;
        w_flush_ex = 1'b1;
      end else if (w_load_use) begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_flush_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_stall_if && (r_stall_cycles != c_stall_cnt_max)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign bus.stall_IF     = w_stall_if;
  assign bus.stall_ID     = w_stall_id;
  assign bus.stall_EX     = w_stall_ex;
  assign bus.flush_ID     = w_flush_id;
  assign bus.flush_EX     = w_flush_ex;
  assign bus.flush_MEM    = w_flush_mem;
  assign bus.muldiv_start = w_muldiv_start;
  assign bus.stall_cycles = r_stall_cycles;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl. Directed scenarios plus
//                randomized traffic, compared every cycle against a
//                rule-level reference model of the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // Reference model state: mul/div outstanding flag and stall count
  bit   m_busy;
  int   m_cnt;

  typedef struct packed {
    logic sif, sid, sex, fid, fex, fmem, start;
  } exp_t;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected controls from the rules: pending mul/div wins, then a new
  // mul/div request, then a taken branch, then a load-use hazard.
  function automatic exp_t model_out(input bit in_rst);
    exp_t e;
    bit   hz;
    e  = '0;
    hz = bus.memread_EX && (bus.rd_EX != 0) &&
         ((bus.rd_EX == bus.rs1_ID) || (bus.rd_EX == bus.rs2_ID));
    if (in_rst) return e;
`ifdef PIPE_CTRL_MULDIV_EN
    if (m_busy) begin
      if (!bus.muldiv_done) begin
        e.sif = 1; e.sid = 1; e.sex = 1; e.fmem = 1;
      end
      return e;
    end
    if (bus.muldiv_req_EX) begin
      e.sif = 1; e.sid = 1; e.sex = 1; e.fmem = 1; e.start = 1;
      return e;
    end
`endif
    if (bus.branch_taken_EX) begin
      e.fid = 1; e.fex = 1;
    end else if (hz) begin
      e.sif = 1; e.sid = 1; e.fex = 1;
    end
    return e;
  endfunction

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".stall_IF"},     16'(bus.stall_IF),     16'(e.sif));
    chk({tag, ".stall_ID"},     16'(bus.stall_ID),     16'(e.sid));
    chk({tag, ".stall_EX"},     16'(bus.stall_EX),     16'(e.sex));
    chk({tag, ".flush_ID"},     16'(bus.flush_ID),     16'(e.fid));
    chk({tag, ".flush_EX"},     16'(bus.flush_EX),     16'(e.fex));
    chk({tag, ".flush_MEM"},    16'(bus.flush_MEM),    16'(e.fmem));
    chk({tag, ".muldiv_start"}, 16'(bus.muldiv_start), 16'(e.start));
    chk({tag, ".stall_cycles"}, bus.stall_cycles,      16'(m_cnt));
  endtask

  // One pipeline cycle: drive at negedge, check mid-cycle, advance model at
  // the rising edge.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic mr, input logic [4:0] rd, input logic br,
                      input logic req, input logic done);
    exp_t e;
    @(negedge clk);
    bus.rs1_ID = rs1; bus.rs2_ID = rs2; bus.memread_EX = mr; bus.rd_EX = rd;
    bus.branch_taken_EX = br; bus.muldiv_req_EX = req; bus.muldiv_done = done;
    #1;
    e = model_out(1'b0);
    chk_outputs(tag, e);
    @(posedge clk);
    if (e.sif && m_cnt < 65535) m_cnt++;
`ifdef PIPE_CTRL_MULDIV_EN
    m_busy = m_busy ? !done : req;
`endif
  endtask

  task automatic idle_inputs();
    bus.rs1_ID = 0; bus.rs2_ID = 0; bus.memread_EX = 0; bus.rd_EX = 0;
    bus.branch_taken_EX = 0; bus.muldiv_req_EX = 0; bus.muldiv_done = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_busy = 0; m_cnt = 0;
    chk_outputs(tag, model_out(1'b1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int base;

  initial begin
    n_pass = 0; n_total = 0; m_busy = 0; m_cnt = 0;
    rst = 1'b0;
    idle_inputs();

    do_reset("reset");

    // Load-use on rs2: single stall cycle, counter 0 -> 1
    step("lu",      5'd1, 5'd5, 1, 5'd5, 0, 0, 0);
    step("lu_next", 5'd1, 5'd5, 0, 5'd5, 0, 0, 0);
    chk("lu_count", bus.stall_cycles, 16'd1);

    // Load into x0 never stalls
    step("x0_load", 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);

    // Branch together with load-use: flush wins, no stall
    step("br_lu", 5'd7, 5'd2, 1, 5'd7, 1, 0, 0);

    // muldiv_done while in RUN is ignored
    step("done_run", 5'd3, 5'd4, 0, 5'd9, 0, 0, 1);

    // Mul/div held in EX, done four cycles after the request
    base = m_cnt;
    step("md_req",  5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
    step("md_w1",   5'd1, 5'd3, 1, 5'd3, 1, 1, 0);
    step("md_w2",   5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
    step("md_w3",   5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
    step("md_done", 5'd1, 5'd2, 0, 5'd3, 0, 1, 1);
    step("md_after", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0);
`ifdef PIPE_CTRL_MULDIV_EN
    chk("md_count", bus.stall_cycles, 16'(base + 4));
`else
    chk("md_count", bus.stall_cycles, 16'(base));
`endif

    // Reset in the second MD_WAIT cycle abandons the operation
    step("rmd_req", 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    step("rmd_w1",  5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    do_reset("rmd_rst");
    chk("rmd_count", bus.stall_cycles, 16'd0);
    step("rmd_done",  5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    step("rmd_after", 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);

    // Randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step("rand",
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 3) == 0));
    end

    // Saturation: sustained load-use stall well past 16 bits
    do_reset("sat_rst");
    @(negedge clk);
    idle_inputs();
    bus.memread_EX = 1; bus.rd_EX = 5'd6; bus.rs1_ID = 5'd6;
    repeat (70000) @(posedge clk);
    m_cnt = 65535;
    @(negedge clk);
    chk("sat_count", bus.stall_cycles, 16'hFFFF);
    step("sat_hold", 5'd6, 5'd0, 1, 5'd6, 0, 0, 0);
    step("sat_idle", 5'd0, 5'd0, 0, 5'd6, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, pipeline clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst input 1, asynchronous, active-high reset.
REQ-003 SHALL have ports: rs1_ID, rs2_ID input 5 each, source register indices of the instruction in ID.
REQ-004 SHALL have ports: memread_EX input 1 (load in EX) and rd_EX input 5 (its destination).
REQ-005 SHALL have ports: branch_taken_EX input 1, redirect resolved in EX.
REQ-006 SHALL have ports: muldiv_req_EX input 1 (mul/div in EX) and muldiv_done input 1 (one-cycle completion pulse from the mul/div unit).
REQ-007 SHALL have ports: stall_IF, stall_ID, stall_EX output 1 each; hold the PC and the IF/ID and ID/EX registers.
REQ-008 SHALL have ports: flush_ID, flush_EX, flush_MEM output 1 each; load a bubble into IF/ID, ID/EX and EX/MEM.
REQ-009 SHALL have ports: muldiv_start output 1, one-cycle start pulse to the mul/div unit.
REQ-010 SHALL have ports: stall_cycles output 16, saturating count of cycles with stall_IF=1.

Function
REQ-011 SHALL implement FSM states RUN and MD_WAIT.
REQ-012 Load-use SHALL be detected when memread_EX=1, rd_EX!=0, and rd_EX equals rs1_ID or rs2_ID.
REQ-013 On load-use in RUN with no branch, outputs SHALL be stall_IF=1, stall_ID=1, flush_EX=1 for exactly that cycle, with no registered delay.
REQ-014 A load with rd_EX=0 SHALL never cause a stall.
REQ-015 On branch_taken_EX=1 in RUN, outputs SHALL be flush_ID=1 and flush_EX=1, and load-use stalls are suppressed that cycle (branch priority).
REQ-016 On muldiv_req_EX=1 in RUN, muldiv_start SHALL be 1 that cycle; next state is MD_WAIT.
REQ-017 On muldiv_req_EX=1 in RUN, stall_IF, stall_ID and stall_EX SHALL be 1 and flush_MEM SHALL be 1 combinationally in that cycle.
REQ-018 In MD_WAIT with muldiv_done=0, outputs SHALL be stall_IF=stall_ID=stall_EX=1 and flush_MEM=1; muldiv_start=0; branch and load-use are ignored.
REQ-019 In MD_WAIT with muldiv_done=1, all stalls and flushes SHALL be 0 that cycle and the next state is RUN.
REQ-020 After returning to RUN, a mul/div instruction in EX SHALL NOT be restarted, because the pipeline advances on the done cycle.
REQ-021 muldiv_done SHALL be ignored in RUN.
REQ-022 Priority SHALL be MD_WAIT > muldiv_req_EX > branch_taken_EX > load-use.
REQ-023 stall_cycles SHALL increment by 1 each cycle stall_IF=1 and hold at 16'hFFFF.
REQ-024 All outputs except stall_cycles SHALL be combinational from the state and the inputs.

Reset
REQ-025 rst=1 SHALL force state to RUN and stall_cycles to 0 immediately, without waiting for a clock edge.
REQ-026 During reset, all stall, flush and muldiv_start outputs SHALL be 0.
REQ-027 Reset mid-MD_WAIT SHALL abandon the operation; a later muldiv_done SHALL be ignored.

Configuration
REQ-028 The macro PIPE_CTRL_MULDIV_EN SHALL control mul/div support.
REQ-029 With PIPE_CTRL_MULDIV_EN defined, behaviour SHALL be as REQ-016..REQ-021.
REQ-030 Without PIPE_CTRL_MULDIV_EN, MD_WAIT SHALL be unreachable, muldiv_start and stall_EX tied 0, flush_MEM tied 0, and muldiv_req_EX and muldiv_done ignored.

Structure
REQ-031 Shared package pipe_ctrl_pkg SHALL hold the state typedef (RUN, MD_WAIT), the REG_X0=5'd0 constant and the stall counter width constant (16).
REQ-032 Sub-module hazard_detect SHALL hold the combinational load-use compare of REQ-012/REQ-014; pipe_ctrl instantiates it once.

Verification
REQ-033 Load-use: memread_EX=1, rd_EX=5, rs2_ID=5 -> one cycle of stall_IF=stall_ID=flush_EX=1; stall_cycles 0->1.
REQ-034 x0 load: memread_EX=1, rd_EX=0, rs1_ID=0 -> no stall, no flush.
REQ-035 Branch plus load-use in the same cycle -> flush_ID=flush_EX=1, stall_IF=0.
REQ-036 Mul/div: muldiv_req_EX=1, muldiv_done 4 cycles later -> muldiv_start one pulse; stalls and flush_MEM held for 4 cycles, 0 on the done cycle; state RUN after; stall_cycles=4.
REQ-037 rst asserted on cycle 2 of MD_WAIT -> outputs 0 asynchronously, stall_cycles=0; a following muldiv_done has no effect.
REQ-038 Saturation: force 70000 stall cycles -> stall_cycles=16'hFFFF.
